// File: rtl/timing_6502.sv
// Cycle sequencer for the 6502 core: owns the T-state, latches RESET/NMI/IRQ and injects BRK.
// Optional: define NMI_IRQ_SYNC_EN to pass nmi_n/irq_n through 2-flop synchronisers.
module timing_6502 #(
  parameter int unsigned RESET_HOLD = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       READY,
  input  logic       RnW,
  input  logic       NEXT_T,
  input  logic       CLEAR_T,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       I_flag,
  output logic [5:0] T_state,
  output logic       SD1,
  output logic       SD2,
  output logic       RESET_req,
  output logic       NMI_req,
  output logic       INJECT_BRK,
  output logic       SYNC
);

  localparam int unsigned HOLD_W      = (RESET_HOLD > 1) ? RESET_HOLD - 1 : 1;
  localparam logic        HOLD_BYPASS = (RESET_HOLD < 2);

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_SD1, S_SD2
  } state_t;

  state_t              state, state_nxt;
  logic [1:0]          fix_cnt, fix_nxt;
  logic [HOLD_W-1:0]   hold_sr, hold_nxt;
  logic                nmi_prev, nmi_prev_nxt;
  logic                nmi_pend, nmi_pend_nxt;
  logic                nmi_again, nmi_again_nxt;
  logic                irq_pend, irq_pend_nxt;
  logic                reset_req_nxt, nmi_req_nxt, inject_nxt;
  logic                sd1_nxt, sd2_nxt, sync_nxt;
  logic [5:0]          t_state_nxt;
  logic                nmi_edge, irq_take;
  logic                nmi_s_c, irq_s_c, advance_c, reset_take_c, irq_now_c;

`ifdef NMI_IRQ_SYNC_EN
  logic [1:0] nmi_sync, irq_sync;
  always_ff @(posedge clk) begin
    nmi_sync <= {nmi_sync[0], nmi_n};
    irq_sync <= {irq_sync[0], irq_n};
  end
  assign nmi_s_c = nmi_sync[1];
  assign irq_s_c = irq_sync[1];
`else
  assign nmi_s_c = nmi_n;
  assign irq_s_c = irq_n;
`endif

  // Write cycles are never stalled by RDY.
  assign advance_c    = clk_en & ~(~READY & RnW);
  assign reset_take_c = clk_en & reset & (HOLD_BYPASS | (&hold_sr));
  assign irq_now_c    = ~irq_s_c & ~I_flag;

  function automatic logic [5:0] t_decode(input state_t s);
    case (s)
      S_T0:    t_decode = 6'b000001;
      S_T1:    t_decode = 6'b000010;
      S_T2:    t_decode = 6'b000100;
      S_T3:    t_decode = 6'b001000;
      S_T4:    t_decode = 6'b010000;
      S_T5:    t_decode = 6'b100000;
      default: t_decode = 6'b000000;
    endcase
  endfunction

  always_comb begin
    state_nxt     = state;
    fix_nxt       = fix_cnt;
    hold_nxt      = hold_sr;
    nmi_prev_nxt  = nmi_prev;
    nmi_pend_nxt  = nmi_pend;
    nmi_again_nxt = nmi_again;
    irq_pend_nxt  = irq_pend;
    reset_req_nxt = RESET_req;
    nmi_req_nxt   = NMI_req;
    inject_nxt    = INJECT_BRK;
    t_state_nxt   = T_state;
    sd1_nxt       = SD1;
    sd2_nxt       = SD2;
    sync_nxt      = SYNC;
    nmi_edge      = 1'b0;
    irq_take      = 1'b0;

    if (clk_en) hold_nxt = (hold_sr << 1) | HOLD_W'(reset);

    if (advance_c) begin
      case (state)
        S_T0:    state_nxt = (NEXT_T && fix_cnt < 2'd2) ? S_T0 : S_T1;
        S_T1:    state_nxt = NEXT_T ? S_T0 : S_T2;
        S_T2:    state_nxt = CLEAR_T ? S_SD1 : (NEXT_T ? S_T3 : S_T0);
        S_T3:    state_nxt = CLEAR_T ? S_SD1 : (NEXT_T ? S_T4 : S_T0);
        S_T4:    state_nxt = CLEAR_T ? S_SD1 : (NEXT_T ? S_T5 : S_T0);
        S_T5:    state_nxt = CLEAR_T ? S_SD1 : (NEXT_T ? S_T6 : S_T0);
        S_T6:    state_nxt = NEXT_T ? S_T0 : S_T1;
        S_SD1:   state_nxt = S_SD2;
        S_SD2:   state_nxt = S_T0;
        default: state_nxt = S_T1;
      endcase
      fix_nxt = (state == S_T0 && state_nxt == S_T0) ? fix_cnt + 2'd1 : 2'd0;

      nmi_prev_nxt = nmi_s_c;
      nmi_edge     = nmi_prev & ~nmi_s_c;
      // IRQ level is taken live on the T0 exit, from the latched sample otherwise.
      irq_take     = (state == S_T0) ? irq_now_c : irq_pend;
      if (state == S_T0 && state_nxt != S_T0) irq_pend_nxt = irq_now_c;

      // Instruction boundary: decide whether IR gets a forced BRK.
      if (state_nxt == S_T1) begin
        inject_nxt = ~RESET_req | nmi_pend | irq_take;
        if (RESET_req && nmi_pend) begin
          nmi_req_nxt = 1'b0;
        end else if (RESET_req && NMI_req && nmi_again) begin
          nmi_pend_nxt  = 1'b1;
          nmi_again_nxt = 1'b0;
        end
      end

      // Vector fetch done; a pending NMI survives an IRQ/reset service.
      if (state == S_T5 && INJECT_BRK) begin
        reset_req_nxt = 1'b1;
        inject_nxt    = 1'b0;
        if (!NMI_req) begin
          nmi_req_nxt  = 1'b1;
          nmi_pend_nxt = 1'b0;
        end
      end

      // An edge during NMI service is held back until after one handler instruction.
      if (nmi_edge) begin
        if (NMI_req) nmi_pend_nxt  = 1'b1;
        else         nmi_again_nxt = 1'b1;
      end

      t_state_nxt = t_decode(state_nxt);
      sd1_nxt     = (state_nxt == S_SD1);
      sd2_nxt     = (state_nxt == S_SD2);
      sync_nxt    = (state_nxt == S_T1);
    end

    if (reset_take_c) begin
      state_nxt     = S_T1;
      fix_nxt       = 2'd0;
      nmi_prev_nxt  = nmi_s_c;
      nmi_pend_nxt  = 1'b0;
      nmi_again_nxt = 1'b0;
      irq_pend_nxt  = 1'b0;
      reset_req_nxt = 1'b0;
      nmi_req_nxt   = 1'b1;
      inject_nxt    = 1'b1;
      t_state_nxt   = 6'b000010;
      sd1_nxt       = 1'b0;
      sd2_nxt       = 1'b0;
      sync_nxt      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    state      <= state_nxt;
    fix_cnt    <= fix_nxt;
    hold_sr    <= hold_nxt;
    nmi_prev   <= nmi_prev_nxt;
    nmi_pend   <= nmi_pend_nxt;
    nmi_again  <= nmi_again_nxt;
    irq_pend   <= irq_pend_nxt;
    RESET_req  <= reset_req_nxt;
    NMI_req    <= nmi_req_nxt;
    INJECT_BRK <= inject_nxt;
    T_state    <= t_state_nxt;
    SD1        <= sd1_nxt;
    SD2        <= sd2_nxt;
    SYNC       <= sync_nxt;
  end

endmodule

// File: tb/tb_timing_6502.sv
// Directed self-checking bench for timing_6502 (default build, RESET_HOLD=2).
module tb_timing_6502;

  logic       clk = 1'b0;
  logic       reset, clk_en, READY, RnW, NEXT_T, CLEAR_T, nmi_n, irq_n, I_flag;
  logic [5:0] T_state;
  logic       SD1, SD2, RESET_req, NMI_req, INJECT_BRK, SYNC;

  int total = 0;
  int bad   = 0;

  localparam logic [5:0] T0 = 6'b000001, T1 = 6'b000010, T2 = 6'b000100;
  localparam logic [5:0] T3 = 6'b001000, T4 = 6'b010000, T5 = 6'b100000;
  localparam logic [5:0] TZ = 6'b000000;

  timing_6502 #(.RESET_HOLD(2)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .READY(READY), .RnW(RnW),
    .NEXT_T(NEXT_T), .CLEAR_T(CLEAR_T), .nmi_n(nmi_n), .irq_n(irq_n), .I_flag(I_flag),
    .T_state(T_state), .SD1(SD1), .SD2(SD2), .RESET_req(RESET_req), .NMI_req(NMI_req),
    .INJECT_BRK(INJECT_BRK), .SYNC(SYNC)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs an injected BRK from T1 through T5 and out to T0.
  task automatic run_brk();
    NEXT_T = 1'b0; step();
    NEXT_T = 1'b1; step(); step(); step();
    NEXT_T = 1'b0; step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step(); step();
    reset = 1'b0;
    total++; if (T_state !== T1) begin bad++; $display("FAIL reset_tstate: got %b want %b", T_state, T1); end
    total++; if (RESET_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", RESET_req); end
    total++; if (INJECT_BRK !== 1'b1) begin bad++; $display("FAIL reset_inject: got %b want 1", INJECT_BRK); end
    total++; if ({NMI_req, SYNC, SD1, SD2} !== 4'b1100) begin bad++; $display("FAIL reset_misc: got %b want 1100", {NMI_req, SYNC, SD1, SD2}); end
    NEXT_T = 1'b0; step();
    total++; if (T_state !== T2) begin bad++; $display("FAIL walk_t2: got %b want %b", T_state, T2); end
    NEXT_T = 1'b1; step();
    total++; if (T_state !== T3) begin bad++; $display("FAIL walk_t3: got %b want %b", T_state, T3); end
    step();
    total++; if (T_state !== T4) begin bad++; $display("FAIL walk_t4: got %b want %b", T_state, T4); end
    step();
    total++; if (T_state !== T5 || RESET_req !== 1'b0) begin bad++; $display("FAIL walk_t5: got %b/%b want %b/0", T_state, RESET_req, T5); end
    NEXT_T = 1'b0; step();
    total++; if (T_state !== T0) begin bad++; $display("FAIL walk_t0: got %b want %b", T_state, T0); end
    total++; if (RESET_req !== 1'b1 || INJECT_BRK !== 1'b0) begin bad++; $display("FAIL reset_exit: req=%b inj=%b want 1/0", RESET_req, INJECT_BRK); end
    step();
    total++; if (T_state !== T1 || INJECT_BRK !== 1'b0 || SYNC !== 1'b1) begin bad++; $display("FAIL post_reset_t1: t=%b inj=%b sync=%b", T_state, INJECT_BRK, SYNC); end
  endtask

  task automatic test_reset_short();
    NEXT_T = 1'b0; reset = 1'b1; step();
    reset = 1'b0;
    total++; if (T_state !== T2 || RESET_req !== 1'b1) begin bad++; $display("FAIL short_reset: t=%b req=%b want %b/1", T_state, RESET_req, T2); end
    step();
    total++; if (T_state !== T0) begin bad++; $display("FAIL t2_to_t0: got %b want %b", T_state, T0); end
    step();
    total++; if (T_state !== T1) begin bad++; $display("FAIL t0_to_t1: got %b want %b", T_state, T1); end
  endtask

  task automatic test_rmw();
    NEXT_T = 1'b0; step();
    NEXT_T = 1'b1; step();
    total++; if (T_state !== T3) begin bad++; $display("FAIL rmw_t3: got %b want %b", T_state, T3); end
    CLEAR_T = 1'b1; step();
    CLEAR_T = 1'b0; NEXT_T = 1'b1;
    total++; if (T_state !== TZ || SD1 !== 1'b1 || SD2 !== 1'b0) begin bad++; $display("FAIL rmw_sd1: t=%b sd1=%b sd2=%b", T_state, SD1, SD2); end
    step();
    total++; if (T_state !== TZ || SD1 !== 1'b0 || SD2 !== 1'b1) begin bad++; $display("FAIL rmw_sd2: t=%b sd1=%b sd2=%b", T_state, SD1, SD2); end
    step();
    NEXT_T = 1'b0;
    total++; if (T_state !== T0 || SD2 !== 1'b0) begin bad++; $display("FAIL rmw_t0: t=%b sd2=%b want %b/0", T_state, SD2, T0); end
    step();
    total++; if (T_state !== T1) begin bad++; $display("FAIL rmw_t1: got %b want %b", T_state, T1); end
  endtask

  task automatic test_stall();
    NEXT_T = 1'b0; step();
    READY = 1'b0; RnW = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (T_state !== T2) begin bad++; $display("FAIL stall_read_%0d: got %b want %b", i, T_state, T2); end
    end
    RnW = 1'b0; step();
    total++; if (T_state !== T0) begin bad++; $display("FAIL stall_write: got %b want %b", T_state, T0); end
    READY = 1'b1; RnW = 1'b1; clk_en = 1'b0;
    step(); step();
    total++; if (T_state !== T0) begin bad++; $display("FAIL clk_en_hold: got %b want %b", T_state, T0); end
    clk_en = 1'b1; step();
    total++; if (T_state !== T1) begin bad++; $display("FAIL clk_en_resume: got %b want %b", T_state, T1); end
  endtask

  task automatic test_irq();
    NEXT_T = 1'b1; step();
    NEXT_T = 1'b0; irq_n = 1'b0; I_flag = 1'b0; step();
    total++; if (T_state !== T1 || INJECT_BRK !== 1'b1 || NMI_req !== 1'b1) begin bad++; $display("FAIL irq_taken: t=%b inj=%b nmi=%b", T_state, INJECT_BRK, NMI_req); end
    irq_n = 1'b1; I_flag = 1'b1;
    run_brk();
    total++; if (T_state !== T0 || INJECT_BRK !== 1'b0) begin bad++; $display("FAIL irq_exit: t=%b inj=%b", T_state, INJECT_BRK); end
    irq_n = 1'b0; step();
    total++; if (T_state !== T1 || INJECT_BRK !== 1'b0) begin bad++; $display("FAIL irq_masked: t=%b inj=%b want %b/0", T_state, INJECT_BRK, T1); end
    irq_n = 1'b1;
  endtask

  task automatic test_nmi();
    nmi_n = 1'b0; irq_n = 1'b0; I_flag = 1'b0; NEXT_T = 1'b1; step();
    NEXT_T = 1'b0; step();
    total++; if (T_state !== T1 || NMI_req !== 1'b0 || INJECT_BRK !== 1'b1) begin bad++; $display("FAIL nmi_taken: t=%b nmi=%b inj=%b", T_state, NMI_req, INJECT_BRK); end
    run_brk();
    total++; if (NMI_req !== 1'b1 || INJECT_BRK !== 1'b0) begin bad++; $display("FAIL nmi_exit: nmi=%b inj=%b want 1/0", NMI_req, INJECT_BRK); end
    step();
    total++; if (T_state !== T1 || INJECT_BRK !== 1'b1 || NMI_req !== 1'b1) begin bad++; $display("FAIL irq_after_nmi: t=%b inj=%b nmi=%b", T_state, INJECT_BRK, NMI_req); end
    nmi_n = 1'b1; irq_n = 1'b1; I_flag = 1'b1;
    run_brk();
    step();
    total++; if (T_state !== T1 || INJECT_BRK !== 1'b0) begin bad++; $display("FAIL nmi_idle: t=%b inj=%b", T_state, INJECT_BRK); end
  endtask

  task automatic test_nmi_reentry();
    nmi_n = 1'b0; NEXT_T = 1'b1; step();
    NEXT_T = 1'b0; step();
    total++; if (NMI_req !== 1'b0) begin bad++; $display("FAIL reentry_first: nmi=%b want 0", NMI_req); end
    nmi_n = 1'b1; step();
    nmi_n = 1'b0; NEXT_T = 1'b1; step(); step(); step();
    NEXT_T = 1'b0; step();
    total++; if (T_state !== T0 || NMI_req !== 1'b1) begin bad++; $display("FAIL reentry_exit: t=%b nmi=%b", T_state, NMI_req); end
    step();
    total++; if (T_state !== T1 || INJECT_BRK !== 1'b0) begin bad++; $display("FAIL reentry_handler: t=%b inj=%b want %b/0", T_state, INJECT_BRK, T1); end
    NEXT_T = 1'b1; step();
    NEXT_T = 1'b0; step();
    total++; if (INJECT_BRK !== 1'b1 || NMI_req !== 1'b0) begin bad++; $display("FAIL reentry_second: inj=%b nmi=%b want 1/0", INJECT_BRK, NMI_req); end
    nmi_n = 1'b1;
    run_brk();
    step();
    total++; if (INJECT_BRK !== 1'b0 || NMI_req !== 1'b1) begin bad++; $display("FAIL reentry_done: inj=%b nmi=%b", INJECT_BRK, NMI_req); end
  endtask

  task automatic test_fixup();
    NEXT_T = 1'b1; step();
    total++; if (T_state !== T0) begin bad++; $display("FAIL fix_enter: got %b want %b", T_state, T0); end
    step();
    total++; if (T_state !== T0) begin bad++; $display("FAIL fix_extra1: got %b want %b", T_state, T0); end
    step();
    total++; if (T_state !== T0) begin bad++; $display("FAIL fix_extra2: got %b want %b", T_state, T0); end
    step();
    total++; if (T_state !== T1) begin bad++; $display("FAIL fix_forced: got %b want %b", T_state, T1); end
  endtask

  task automatic test_t6();
    NEXT_T = 1'b0; step();
    NEXT_T = 1'b1; step(); step(); step(); step();
    total++; if (T_state !== TZ || SD1 !== 1'b0 || SD2 !== 1'b0) begin bad++; $display("FAIL t6: t=%b sd1=%b sd2=%b", T_state, SD1, SD2); end
    NEXT_T = 1'b0; step();
    total++; if (T_state !== T1) begin bad++; $display("FAIL t6_to_t1: got %b want %b", T_state, T1); end
  endtask

  task automatic test_reset_mid_rmw();
    NEXT_T = 1'b0; step();
    NEXT_T = 1'b1; step();
    CLEAR_T = 1'b1; step();
    CLEAR_T = 1'b0; reset = 1'b1; step();
    total++; if (SD2 !== 1'b1 || RESET_req !== 1'b1) begin bad++; $display("FAIL rmw_reset_first: sd2=%b req=%b want 1/1", SD2, RESET_req); end
    step();
    reset = 1'b0;
    total++; if (T_state !== T1 || SD2 !== 1'b0 || RESET_req !== 1'b0 || INJECT_BRK !== 1'b1) begin bad++; $display("FAIL rmw_reset_taken: t=%b sd2=%b req=%b inj=%b", T_state, SD2, RESET_req, INJECT_BRK); end
  endtask

  initial begin
    reset = 1'b0; clk_en = 1'b1; READY = 1'b1; RnW = 1'b1; NEXT_T = 1'b0; CLEAR_T = 1'b0;
    nmi_n = 1'b1; irq_n = 1'b1; I_flag = 1'b1;
    #1;
    test_reset();
    test_reset_short();
    test_rmw();
    test_stall();
    test_irq();
    test_nmi();
    test_nmi_reentry();
    test_fixup();
    test_t6();
    test_reset_mid_rmw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
